// File: rtl/rf_handle_cache.sv
// rf_handle_cache
//   Resolves a hashed object key to a simulator object handle through a
//   small fully-associative cache. A miss goes to the object table, and a
//   successful (non-error) answer fills the cache.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready/key      lookup request
//   rsp_valid/ready          response handshake
//   rsp_handle/hit/err       response payload (handle is 0 on err)
//   tbl_req_valid/ready/key  miss request to the object table
//   tbl_rsp_valid/handle/err object table answer (no ready)
//   flush                    invalidate every entry, reset victim pointer
//   hit_cnt, miss_cnt        saturating lookup statistics
module rf_handle_cache #(
  parameter int ENTRIES  = 8,
  parameter int KEY_W    = 32,
  parameter int HANDLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_W-1:0]    req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [HANDLE_W-1:0] rsp_handle,
  output logic                rsp_hit,
  output logic                rsp_err,
  output logic                tbl_req_valid,
  input  logic                tbl_req_ready,
  output logic [KEY_W-1:0]    tbl_req_key,
  input  logic                tbl_rsp_valid,
  input  logic [HANDLE_W-1:0] tbl_rsp_handle,
  input  logic                tbl_rsp_err,
  input  logic                flush,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, RESP} state_t;

  state_t                state_q;
  logic [ENTRIES-1:0]    valid_q;
  logic [KEY_W-1:0]      key_mem_q [ENTRIES];
  logic [HANDLE_W-1:0]   hdl_mem_q [ENTRIES];
  logic [PTR_W-1:0]      rr_q;
  logic                  kill_q;
  logic                  rsp_valid_q;
  logic [HANDLE_W-1:0]   rsp_handle_q;
  logic                  rsp_hit_q;
  logic                  rsp_err_q;
  logic                  tbl_req_valid_q;
  logic [KEY_W-1:0]      tbl_req_key_q;
  logic [15:0]           hit_cnt_q;
  logic [15:0]           miss_cnt_q;

  logic                  hit_any;
  logic [PTR_W-1:0]      hit_idx;
  logic                  inv_any;
  logic [PTR_W-1:0]      inv_idx;
  logic [PTR_W-1:0]      victim;
  logic                  lookup_hit;
  logic                  fill_en;

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (key_mem_q[i] == req_key)) begin
        hit_any = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
    // Walk downward so the lowest-index invalid entry wins.
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_idx = PTR_W'(i);
      end
    end
    victim     = inv_any ? inv_idx : rr_q;
    // A flush arriving with the request is seen as already applied.
    lookup_hit = hit_any && !flush;
    // Fill is dropped if a flush landed at any point during the miss.
    fill_en    = !rst && (state_q == MISS_WAIT) && tbl_rsp_valid &&
                 !tbl_rsp_err && !kill_q && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      rr_q            <= '0;
      kill_q          <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_handle_q    <= '0;
      rsp_hit_q       <= 1'b0;
      rsp_err_q       <= 1'b0;
      tbl_req_valid_q <= 1'b0;
      tbl_req_key_q   <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (lookup_hit) begin
              rsp_handle_q <= hdl_mem_q[hit_idx];
              rsp_hit_q    <= 1'b1;
              rsp_err_q    <= 1'b0;
              rsp_valid_q  <= 1'b1;
              if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
              state_q      <= RESP;
            end else begin
              tbl_req_valid_q <= 1'b1;
              tbl_req_key_q   <= req_key;
              kill_q          <= 1'b0;
              if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
              state_q         <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (tbl_req_ready) begin
            tbl_req_valid_q <= 1'b0;
            state_q         <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (tbl_rsp_valid) begin
            rsp_handle_q <= tbl_rsp_err ? '0 : tbl_rsp_handle;
            rsp_hit_q    <= 1'b0;
            rsp_err_q    <= tbl_rsp_err;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (flush && ((state_q == MISS_REQ) || (state_q == MISS_WAIT))) kill_q <= 1'b1;

      if (flush) begin
        valid_q <= '0;
        rr_q    <= '0;
      end else if (fill_en) begin
        valid_q[victim] <= 1'b1;
        // Pointer only advances when a valid entry is evicted.
        if (!inv_any) rr_q <= rr_q + 1'b1;
      end
    end
  end

  // Entry payload storage; only the valid bits need reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      key_mem_q[victim] <= tbl_req_key_q;
      hdl_mem_q[victim] <= tbl_rsp_handle;
    end
  end

  // Held low while rst is asserted, high as soon as the block idles.
  assign req_ready     = (state_q == IDLE) && !rst;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_handle    = rsp_handle_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_err       = rsp_err_q;
  assign tbl_req_valid = tbl_req_valid_q;
  assign tbl_req_key   = tbl_req_key_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: doc/rf_handle_cache.md
# rf_handle_cache

Handle-lookup front end for the reflection manager: resolves a hashed object key (name hash of a variable, class, package or module) to a simulator object handle. Keys are held in a small fully-associative cache; a miss is forwarded to the downstream object-table interface, and a successful answer fills the cache. The reflection manager consumes this block's response stream.

## Interface
Parameters:
- ENTRIES, 8, number of cache entries (power of two, 2..32)
- KEY_W, 32, key (name-hash) width
- HANDLE_W, 16, object handle width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  block accepts request
- req_key  in  KEY_W  key to resolve
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_handle  out  HANDLE_W  resolved handle (0 when rsp_err)
- rsp_hit  out  1  response served from cache
- rsp_err  out  1  object table reported key unknown
- tbl_req_valid  out  1  miss request to object table
- tbl_req_ready  in  1  object table accepts request
- tbl_req_key  out  KEY_W  key being fetched
- tbl_rsp_valid  in  1  object table answer (always accepted, no ready)
- tbl_rsp_handle  in  HANDLE_W  fetched handle
- tbl_rsp_err  in  1  key unknown
- flush  in  1  invalidate all entries
- hit_cnt  out  16  saturating hit counter
- miss_cnt  out  16  saturating miss counter

## Operation
- States: IDLE, MISS_REQ, MISS_WAIT, RESP.
- IDLE: req_ready=1. On req_valid, key is registered and compared against all valid entries.
  - Hit: load rsp_handle from matching entry, rsp_hit=1, rsp_err=0, hit_cnt++, go to RESP.
  - Miss: miss_cnt++, go to MISS_REQ.
- MISS_REQ: tbl_req_valid=1, tbl_req_key=registered key; key held stable until tbl_req_ready; then MISS_WAIT.
- MISS_WAIT: on tbl_rsp_valid capture handle/err, rsp_hit=0; if err=0 fill cache; go to RESP. tbl_rsp_valid in any other state is ignored.
- RESP: rsp_valid=1, outputs stable until rsp_ready; then IDLE.
- Fill victim: lowest-index invalid entry; if none, entry at round-robin pointer, pointer increments (mod ENTRIES) on each victim fill only.
- Error answers never fill; rsp_handle=0 when rsp_err=1.
- Duplicate keys never co-exist (fill happens only after miss on that key).
- flush: clears all valid bits and round-robin pointer next edge; counters unaffected. Flush during MISS_REQ/MISS_WAIT suppresses the pending fill (the response is still delivered). Flush together with an IDLE request: request accepted and looked up against the already-flushed cache (miss).
- Counters saturate at 16'hFFFF, cleared only by rst.

## Timing
- Reset values: req_ready=0 in reset cycle, 1 the cycle after; rsp_valid=0, rsp_handle=0, rsp_hit=0, rsp_err=0, tbl_req_valid=0, tbl_req_key=0, hit_cnt=0, miss_cnt=0; all valid bits and pointer cleared; state IDLE.
- Hit: request accepted cycle N, rsp_valid at N+1. Back-to-back hits with rsp_ready held high: one response every 2 cycles.
- Miss: request at N, tbl_req_valid at N+1; tbl_rsp_valid at cycle M gives rsp_valid at M+1; the filled entry is visible to a request accepted at M+2 or later.
- rst mid-transaction: abandons everything at the next edge, including an outstanding table request; a late tbl_rsp_valid is then ignored.
- tbl_rsp_valid in the same cycle as tbl_req_ready acceptance is ignored (answer must arrive no earlier than the cycle after acceptance).

## Test plan
- Cold miss: key 32'h1234_5678, table answers handle 16'h0042 three cycles later -> tbl_req_key=32'h1234_5678, rsp_handle=16'h0042, rsp_hit=0, miss_cnt=1; repeat key -> rsp_hit=1 at N+1, hit_cnt=1.
- Error path: table returns err for key 32'hDEAD -> rsp_err=1, rsp_handle=0; same key again -> miss again (miss_cnt=2).
- Replacement: fill keys 1..8, then key 9 -> entry 0 evicted; key 1 misses, key 2 hits; key 10 evicts entry 1 (pointer advanced).
- Flush during MISS_WAIT for key 5 -> response handle delivered, subsequent key 5 misses; counters retained.
- Backpressure: rsp_ready low 5 cycles on a hit -> rsp_valid and outputs stable, req_ready=0 throughout; tbl_req_ready low 4 cycles -> tbl_req_key stable.
- Reset in MISS_WAIT then late tbl_rsp_valid -> no response, no fill, counters 0, req_ready=1 the cycle after reset is released.
